// File: rtl/gmsk_burst_sequencer_if.sv
// Handshake and modulator-drive signals of the GMSK burst sequencer.
// master: burst formatter / test side. slave: the sequencer itself.
interface gmsk_burst_sequencer_if #(
   parameter int LEN_BITS = 8
) ();
   logic                burst_start;
   logic [LEN_BITS-1:0] burst_length;
   logic                bit_valid;
   logic                bit_data;
   logic                bit_ready;
   logic                sample_strobe;
   logic                symbol_strobe;
   logic                input_bit;
   logic                busy;
   logic                tx_active;
   logic                burst_done;
   logic                underflow;

   modport master (
      output burst_start, burst_length, bit_valid, bit_data,
      input  bit_ready, sample_strobe, symbol_strobe, input_bit,
             busy, tx_active, burst_done, underflow
   );

   modport slave (
      input  burst_start, burst_length, bit_valid, bit_data,
      output bit_ready, sample_strobe, symbol_strobe, input_bit,
             busy, tx_active, burst_done, underflow
   );
endinterface

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst sequencer: free-running sample/symbol strobes plus burst framing
// (lead tail, payload through a one-bit skid register, trail tail, guard).
// FSM state changes at symbol boundaries; the bit for a boundary is decided
// and registered one cycle earlier (the "load" cycle).
module gmsk_burst_sequencer #(
   parameter int CLOCKS_PER_SAMPLE  = 4,
   parameter int SAMPLES_PER_SYMBOL = 32,
   parameter int TAIL_BITS          = 3,
   parameter int GUARD_SYMBOLS      = 8,
   parameter int LEN_BITS           = 8
) (
   input logic                   clock,
   input logic                   reset_n,
   gmsk_burst_sequencer_if.slave bus
);
   localparam int DIV_W   = $clog2(CLOCKS_PER_SAMPLE);
   localparam int SCNT_W  = $clog2(SAMPLES_PER_SYMBOL);
   localparam int CNT_MAX = (TAIL_BITS > GUARD_SYMBOLS) ? TAIL_BITS : GUARD_SYMBOLS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCKS_PER_SAMPLE - 1);
   localparam logic [DIV_W-1:0]  DIV_SYM   = DIV_W'(CLOCKS_PER_SAMPLE - 2);
   // Cycle before the boundary; wraps into the previous sample when CLOCKS_PER_SAMPLE==2.
   localparam logic [DIV_W-1:0]  DIV_LD    = DIV_W'((2 * CLOCKS_PER_SAMPLE - 3) % CLOCKS_PER_SAMPLE);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [SCNT_W-1:0] SCNT_LD   = SCNT_W'((CLOCKS_PER_SAMPLE >= 3) ?
                                                     SAMPLES_PER_SYMBOL - 1 : SAMPLES_PER_SYMBOL - 2);
   localparam logic [CNT_W-1:0]  TAIL_N    = CNT_W'(TAIL_BITS);
   localparam logic [CNT_W-1:0]  GUARD_N   = CNT_W'(GUARD_SYMBOLS);

   typedef enum logic [2:0] {IDLE, ARMED, LEAD, PAYLOAD, TRAIL, GUARD} state_t;

   state_t              state, state_nx;
   logic [DIV_W-1:0]    div;
   logic [SCNT_W-1:0]   scnt;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [LEN_BITS-1:0] pcnt, pcnt_nx;
   logic [LEN_BITS-1:0] fetched;
   logic [LEN_BITS-1:0] len;
   logic                skid, skid_full;
   logic                bit_q, under_q;
   logic                sample_stb, symbol_stb, load;
   logic                accept, next_payload, ready, xfer, done;

   assign sample_stb = (div == DIV_LAST);
   assign symbol_stb = (scnt == SCNT_LAST) && (div == DIV_SYM);
   assign load       = (scnt == SCNT_LD) && (div == DIV_LD);
   assign accept     = (state == IDLE) && bus.burst_start && (bus.burst_length != '0);
   assign ready      = !skid_full && (state inside {ARMED, LEAD, PAYLOAD}) && (fetched < len);
   assign xfer       = ready && bus.bit_valid;
   // The upcoming boundary carries a payload bit: last lead bit already sent, or payload not finished.
   assign next_payload = load && (((state == LEAD) && (cnt == TAIL_N)) ||
                                  ((state == PAYLOAD) && (pcnt != len)));

   // Free-running clock divider and sample counter; they define all strobe timing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div  <= '0;
         scnt <= '0;
      end else if (sample_stb) begin
         div  <= '0;
         scnt <= (scnt == SCNT_LAST) ? '0 : scnt + SCNT_W'(1);
      end else begin
         div  <= div + DIV_W'(1);
      end
   end

   // FSM state and per-phase symbol counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pcnt  <= pcnt_nx;
      end
   end

   // Next-state logic; every transition out of ARMED..GUARD happens on a boundary.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pcnt_nx  = pcnt;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = ARMED;
               cnt_nx   = '0;
               pcnt_nx  = '0;
            end
         end
         ARMED: begin
            if (symbol_stb) begin
               state_nx = LEAD;
               cnt_nx   = CNT_W'(1);
            end
         end
         LEAD: begin
            if (symbol_stb) begin
               if (cnt == TAIL_N) begin
                  state_nx = PAYLOAD;
                  pcnt_nx  = LEN_BITS'(1);
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         PAYLOAD: begin
            if (symbol_stb) begin
               if (pcnt == len) begin
                  state_nx = TRAIL;
                  cnt_nx   = CNT_W'(1);
               end else begin
                  pcnt_nx = pcnt + LEN_BITS'(1);
               end
            end
         end
         TRAIL: begin
            if (symbol_stb) begin
               if (cnt == TAIL_N) begin
                  state_nx = GUARD;
                  cnt_nx   = CNT_W'(1);
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         GUARD: begin
            if (symbol_stb) begin
               if (cnt == GUARD_N) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
                  pcnt_nx  = '0;
                  done     = 1'b1;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Length latch, skid register, fetch count, sticky underflow and the registered symbol bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len       <= '0;
         fetched   <= '0;
         skid      <= 1'b0;
         skid_full <= 1'b0;
         under_q   <= 1'b0;
         bit_q     <= 1'b0;
      end else begin
         if (accept) begin
            len       <= bus.burst_length;
            fetched   <= '0;
            skid_full <= 1'b0;
            under_q   <= 1'b0;
         end else begin
            if (next_payload) begin
               skid_full <= 1'b0;
               if (!skid_full) under_q <= 1'b1;
            end
            // A fetch can only land when the skid is empty, so it never loses to the consume above.
            if (xfer) begin
               skid      <= bus.bit_data;
               skid_full <= 1'b1;
            end
            // A missing bit still counts as fetched so a late upstream bit is never sent.
            fetched <= fetched + LEN_BITS'(xfer) + LEN_BITS'(next_payload && !skid_full);
         end
         if (load) bit_q <= next_payload && skid_full && skid;
      end
   end

   assign bus.bit_ready     = ready;
   assign bus.sample_strobe = sample_stb;
   assign bus.symbol_strobe = symbol_stb;
   assign bus.input_bit     = bit_q;
   assign bus.busy          = (state != IDLE);
   assign bus.tx_active     = (state inside {LEAD, PAYLOAD, TRAIL, GUARD});
   assign bus.burst_done    = done;
   assign bus.underflow     = under_q;
endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Self-checking bench for gmsk_burst_sequencer. The reference model works on
// absolute cycle numbers since reset release and a per-burst list of symbols.
module tb_gmsk_burst_sequencer;
   localparam int CPS      = 4;
   localparam int SPS      = 32;
   localparam int TAIL     = 3;
   localparam int GUARD    = 8;
   localparam int LEN_BITS = 8;
   localparam int PERIOD   = CPS * SPS;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   gmsk_burst_sequencer_if #(.LEN_BITS(LEN_BITS)) bus ();

   gmsk_burst_sequencer #(
      .CLOCKS_PER_SAMPLE (CPS),
      .SAMPLES_PER_SYMBOL(SPS),
      .TAIL_BITS         (TAIL),
      .GUARD_SYMBOLS     (GUARD),
      .LEN_BITS          (LEN_BITS)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          len;
      logic [15:0] bits;       // bit i = i-th payload bit
      bit          never;      // upstream never offers data
      int          restart_len;
      bit          exp_under;
      int          exp_xfers;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   bit m_active = 1'b0;
   bit m_under  = 1'b0;
   bit m_never  = 1'b0;
   int k        = 0;
   int n_sym    = 0;
   int xfers    = 0;
   int pay_idx  = 0;
   bit sym[$];
   bit pay[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   // Compare every output against the model for the current cycle.
   task automatic model_check();
      bit e_sym;
      int kb;
      bit e_bit;
      e_sym = ((cyc % PERIOD) == PERIOD - 2);
      kb    = k;
      chk("sample_strobe", bus.sample_strobe, (cyc % CPS) == CPS - 1);
      chk("symbol_strobe", bus.symbol_strobe, e_sym);
      if (m_active && e_sym) begin
         k++;
         if (m_never && k == TAIL + 1) m_under = 1'b1;
      end
      chk("busy", bus.busy, m_active);
      chk("tx_active", bus.tx_active, m_active && kb >= 1);
      chk("burst_done", bus.burst_done, m_active && e_sym && k == n_sym + 1);
      chk("underflow", bus.underflow, m_under);
      if (!m_active) chk("bit_ready_idle", bus.bit_ready, 1'b0);
      if (e_sym) begin
         e_bit = 1'b0;
         if (m_active && k <= n_sym) e_bit = sym[k-1];
         chk("input_bit", bus.input_bit, e_bit);
      end
      if (m_active && e_sym && k == n_sym + 1) m_active = 1'b0;
   endtask

   // Upstream formatter: offers the queued payload bits in order.
   task automatic drive_upstream();
      bus.burst_start = 1'b0;
      bus.bit_valid   = m_never ? 1'b0 : ($urandom_range(3) != 0);
      bus.bit_data    = (pay_idx < pay.size()) ? pay[pay_idx] : 1'($urandom_range(1));
      if (bus.bit_ready && bus.bit_valid) begin
         xfers++;
         pay_idx++;
      end
   endtask

   task automatic step();
      @(posedge clock);
      cyc++;
      @(negedge clock);
      model_check();
      drive_upstream();
   endtask

   // Pulse burst_start for the current cycle; the model accepts only when idle with nonzero length.
   task automatic start_burst(input int len, input logic [15:0] bits, input bit never);
      bus.burst_start  = 1'b1;
      bus.burst_length = LEN_BITS'(len);
      if (!m_active && len != 0) begin
         m_active = 1'b1;
         m_under  = 1'b0;
         m_never  = never;
         k        = 0;
         n_sym    = 2 * TAIL + len + GUARD;
         xfers    = 0;
         pay_idx  = 0;
         sym.delete();
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(bits[i]);
         for (int i = 0; i < TAIL; i++) sym.push_back(1'b0);
         for (int i = 0; i < len; i++) sym.push_back(never ? 1'b0 : bits[i]);
         for (int i = 0; i < TAIL + GUARD; i++) sym.push_back(1'b0);
      end
   endtask

   task automatic run_burst(input vec_t v);
      int budget;
      bit restarted;
      start_burst(v.len, v.bits, v.never);
      budget    = (2 * TAIL + v.len + GUARD + 3) * PERIOD;
      restarted = 1'b0;
      while (m_active && budget > 0) begin
         step();
         budget--;
         if (v.restart_len != 0 && !restarted && k == TAIL + 2) begin
            start_burst(v.restart_len, 16'hFFFF, 1'b0);
            restarted = 1'b1;
         end
      end
      if (m_active) begin
         checks++;
         errors++;
         $display("FAIL burst_timeout len=%0d got busy=%0b want burst_done within budget", v.len, bus.busy);
         m_active = 1'b0;
      end
      chk("transfers", xfers, v.exp_xfers);
      chk("underflow_end", bus.underflow, v.exp_under);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
      cyc     = 0;
      model_check();
      drive_upstream();
   endtask

   initial begin
      vec_t vecs[5];
      vec_t r;
      int   budget;

      vecs[0] = '{len: 4,  bits: 16'b1101, never: 1'b0, restart_len: 0, exp_under: 1'b0, exp_xfers: 4};
      vecs[1] = '{len: 2,  bits: 16'b0011, never: 1'b1, restart_len: 0, exp_under: 1'b1, exp_xfers: 0};
      vecs[2] = '{len: 4,  bits: 16'b0110, never: 1'b0, restart_len: 9, exp_under: 1'b0, exp_xfers: 4};
      vecs[3] = '{len: 1,  bits: 16'b0001, never: 1'b0, restart_len: 0, exp_under: 1'b0, exp_xfers: 1};
      vecs[4] = '{len: 16, bits: 16'hA5C3, never: 1'b0, restart_len: 0, exp_under: 1'b0, exp_xfers: 16};

      bus.burst_start  = 1'b0;
      bus.burst_length = '0;
      bus.bit_valid    = 1'b0;
      bus.bit_data     = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_tx_active", bus.tx_active, 1'b0);
      chk("reset_bit_ready", bus.bit_ready, 1'b0);
      chk("reset_input_bit", bus.input_bit, 1'b0);
      chk("reset_underflow", bus.underflow, 1'b0);
      chk("reset_sample_strobe", bus.sample_strobe, 1'b0);
      release_reset();

      // Strobe timing while idle
      repeat (300) step();

      // Directed bursts from the table
      foreach (vecs[i]) begin
         repeat ($urandom_range(150, 1)) step();
         run_burst(vecs[i]);
      end

      // Zero-length request is ignored
      repeat (20) step();
      start_burst(0, 16'h0000, 1'b0);
      repeat (300) step();

      // Randomized bursts
      for (int n = 0; n < 5; n++) begin
         repeat ($urandom_range(200, 1)) step();
         r = '{len: int'($urandom_range(16, 1)), bits: 16'($urandom), never: 1'b0,
               restart_len: 0, exp_under: 1'b0, exp_xfers: 0};
         r.exp_xfers = r.len;
         run_burst(r);
      end

      // Reset asserted during GUARD
      repeat (10) step();
      start_burst(3, 16'b101, 1'b0);
      budget = 30 * PERIOD;
      while (k < n_sym - 3 && budget > 0) begin
         step();
         budget--;
      end
      chk("reached_guard", bus.tx_active, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("async_busy", bus.busy, 1'b0);
      chk("async_tx_active", bus.tx_active, 1'b0);
      chk("async_bit_ready", bus.bit_ready, 1'b0);
      chk("async_burst_done", bus.burst_done, 1'b0);
      m_active = 1'b0;
      m_under  = 1'b0;
      m_never  = 1'b0;
      k        = 0;
      repeat (2) @(negedge clock);
      release_reset();
      repeat (300) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
